countdown_timer: RTL and testbench

Loadable down-counter with auto-reload and a done/acknowledge handshake: the decrementing counterpart of the team's up-counter with rollover flag. Software or an upstream FSM loads a start value. The block counts it down to terminal on enabled clocks, then either reloads automatically or holds `done` until acknowledged. It serves as the timeout and interval generator beside the up-counters in the lab datapaths.

---
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with auto-reload, done/ack handshake and a saturating expiry tally.
// Latency: load visible one edge after capture; expiry flagged on the edge count leaves 1.
// No backpressure: done is held until done_ack/load/clear/rst, and load always wins over ack.
module countdown_timer #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic                count_enable,
  input  logic                auto_reload,
  input  logic                done_ack,
  output logic [NUM_BITS-1:0] count_out,
  output logic                busy,
  output logic                done,
  output logic                expire_pulse,
  output logic [NUM_BITS-1:0] expire_cnt,
  output logic                load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [NUM_BITS-1:0] ONE      = NUM_BITS'(1);
  localparam logic [NUM_BITS-1:0] ALL_ONES = {NUM_BITS{1'b1}};

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] count_q, count_d;
  logic [NUM_BITS-1:0] reload_q, reload_d;
  logic [NUM_BITS-1:0] exp_cnt_q, exp_cnt_d;
  logic                expire_q, expire_d;
  logic                load_err_q, load_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state: clear > load > done_ack > count_enable; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    exp_cnt_d  = exp_cnt_q;
    expire_d   = 1'b0;
    load_err_d = 1'b0;

    if (clear) begin
      state_d   = S_IDLE;
      count_d   = '0;
      reload_d  = '0;
      exp_cnt_d = '0;
    end else if (load) begin
      if (load_val != '0) begin
        state_d   = S_RUN;
        count_d   = load_val;
        reload_d  = load_val;
        exp_cnt_d = '0;
      end else begin
        // Zero start value is rejected without disturbing the running count.
        load_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (count_enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              expire_d = 1'b1;
              if (exp_cnt_q != ALL_ONES) begin
                exp_cnt_d = exp_cnt_q + ONE;
              end
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end
            // count_q == 0 cannot occur in RUN; hold rather than wrap.
          end
        end
        S_DONE: begin
          if (done_ack) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          // IDLE ignores count_enable and done_ack.
        end
      endcase
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      exp_cnt_q  <= '0;
      expire_q   <= 1'b0;
      load_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      exp_cnt_q  <= exp_cnt_d;
      expire_q   <= expire_d;
      load_err_q <= load_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign count_out    = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign expire_pulse = expire_q;
  assign expire_cnt   = exp_cnt_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected outputs are queued as each step is driven
// and popped for comparison one cycle later, after the clock edge that produces them.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       count_enable;
  logic       auto_reload;
  logic       done_ack;
  logic [7:0] count_out;
  logic       busy;
  logic       done;
  logic       expire_pulse;
  logic [7:0] expire_cnt;
  logic       load_err;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       pulse;
    logic [7:0] ecnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  countdown_timer #(.NUM_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .done_ack     (done_ack),
    .count_out    (count_out),
    .busy         (busy),
    .done         (done),
    .expire_pulse (expire_pulse),
    .expire_cnt   (expire_cnt),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  // Queue the expectation for the coming edge, let the edge happen, then compare.
  task automatic tick(input string tag, input int c, input int b, input int d,
                      input int p, input int ec, input int le);
    exp_t e;
    e.cnt   = 8'(c);
    e.busy  = 1'(b);
    e.done  = 1'(d);
    e.pulse = 1'(p);
    e.ecnt  = 8'(ec);
    e.err   = 1'(le);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, "count_out",    count_out,            e.cnt);
      chk(tag, "busy",         {7'd0, busy},         {7'd0, e.busy});
      chk(tag, "done",         {7'd0, done},         {7'd0, e.done});
      chk(tag, "expire_pulse", {7'd0, expire_pulse}, {7'd0, e.pulse});
      chk(tag, "expire_cnt",   expire_cnt,           e.ecnt);
      chk(tag, "load_err",     {7'd0, load_err},     {7'd0, e.err});
    end
  endtask

  initial begin
    int en;
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'd0;
    count_enable = 1'b0; auto_reload = 1'b0; done_ack = 1'b0;

    // Reset held two cycles.
    tick("rst0", 0, 0, 0, 0, 0, 0);
    tick("rst1", 0, 0, 0, 0, 0, 0);

    // Basic one-shot countdown from 5.
    rst = 1'b0; load = 1'b1; load_val = 8'd5; count_enable = 1'b1; auto_reload = 1'b0;
    tick("load5", 5, 1, 0, 0, 0, 0);
    load = 1'b0;
    tick("dec4", 4, 1, 0, 0, 0, 0);
    tick("dec3", 3, 1, 0, 0, 0, 0);
    tick("dec2", 2, 1, 0, 0, 0, 0);
    tick("dec1", 1, 1, 0, 0, 0, 0);
    tick("expire", 0, 0, 1, 1, 1, 0);

    // DONE holds with count_enable high and no ack; pulse is single-cycle.
    tick("hold0", 0, 0, 1, 0, 1, 0);
    tick("hold1", 0, 0, 1, 0, 1, 0);
    tick("hold2", 0, 0, 1, 0, 1, 0);
    done_ack = 1'b1;
    tick("ack", 0, 0, 0, 0, 1, 0);
    done_ack = 1'b0;
    tick("idle_ce", 0, 0, 0, 0, 1, 0);

    // Auto-reload with gated enable; auto_reload wiggles on disabled edges.
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b1; count_enable = 1'b0;
    tick("load3", 3, 1, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      count_enable = (i % 2) == 1;
      auto_reload  = (i % 2) == 1;
      en = (i + 1) / 2;
      tick("ar3", 3 - (en % 3), 1, 0, (count_enable && (en % 3 == 0)) ? 1 : 0, en / 3, 0);
    end
    count_enable = 1'b1;
    tick("ar3_to2", 2, 1, 0, 0, 4, 0);

    // clear beats load at count 2.
    clear = 1'b1; load = 1'b1; load_val = 8'd9;
    tick("clr_vs_load", 0, 0, 0, 0, 0, 0);
    clear = 1'b0; load = 1'b0;

    // load_val=1 expires on the first enabled edge; then load beats done_ack.
    load = 1'b1; load_val = 8'd1; auto_reload = 1'b0;
    tick("load1", 1, 1, 0, 0, 0, 0);
    load = 1'b0;
    tick("exp1", 0, 0, 1, 1, 1, 0);
    load = 1'b1; load_val = 8'd7; done_ack = 1'b1;
    tick("load_vs_ack", 7, 1, 0, 0, 0, 0);
    load = 1'b0; done_ack = 1'b0; count_enable = 1'b0;
    tick("run_hold", 7, 1, 0, 0, 0, 0);

    // Zero load value: error pulse, state untouched even with enable high.
    load = 1'b1; load_val = 8'd0; count_enable = 1'b1;
    tick("load0", 7, 1, 0, 0, 0, 1);
    load = 1'b0; count_enable = 1'b0;
    tick("load0_after", 7, 1, 0, 0, 0, 0);

    // Full-range period: 255 enabled edges per expiry.
    load = 1'b1; load_val = 8'hFF; auto_reload = 1'b1; count_enable = 1'b1;
    tick("loadFF", 255, 1, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 510; i++) begin
      if (i % 255 == 0) tick("ffwrap", 255, 1, 0, 1, i / 255, 0);
      else              tick("ffdec", 255 - (i % 255), 1, 0, 0, i / 255, 0);
    end

    // Expiry tally saturates at all-ones.
    load = 1'b1; load_val = 8'd1;
    tick("sat_load", 1, 1, 0, 0, 0, 0);
    load = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      tick("sat", 1, 1, 0, 1, (i > 255) ? 255 : i, 0);
    end

    // Reset on the terminal edge suppresses the pulse.
    load = 1'b1; load_val = 8'd2; auto_reload = 1'b0;
    tick("rst_load2", 2, 1, 0, 0, 0, 0);
    load = 1'b0;
    tick("rst_dec1", 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick("rst_term", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick("rst_idle", 0, 0, 0, 0, 0, 0);

    // Clear on the terminal edge also suppresses the pulse.
    load = 1'b1; load_val = 8'd1;
    tick("clr_load1", 1, 1, 0, 0, 0, 0);
    load = 1'b0; clear = 1'b1;
    tick("clr_term", 0, 0, 0, 0, 0, 0);
    clear = 1'b0;
    tick("clr_idle", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
